// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle between the APU sequencer (master)
// and the bit-serial subtractor (slave).
interface serial_subtractor_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrowIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrowOut;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output start, a, b, borrowIn,
        input  busy, done, diff, borrowOut, zero, negative, overflow
    );

    modport slave (
        input  start, a, b, borrowIn,
        output busy, done, diff, borrowOut, zero, negative, overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrowIn, one bit per
// clock LSB first, through a single full-subtractor cell and a registered borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    serial_subtractor_if.slave sub
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] aSh_q, aSh_d, bSh_q, bSh_d, dSh_q, dSh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d, aMsb_q, aMsb_d, bMsb_q, bMsb_d;
    logic             borrowOut_q, borrowOut_d, zero_q, zero_d;
    logic             negative_q, negative_d, overflow_q, overflow_d;
    logic             ai, bi, dBit, brNext;
    logic [WIDTH-1:0] dShifted;

    assign ai       = aSh_q[0];
    assign bi       = bSh_q[0];
    assign dBit     = ai ^ bi ^ br_q;
    assign brNext   = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign dShifted = (dSh_q >> 1) | {dBit, {(WIDTH-1){1'b0}}};

    // The MSBs are latched separately because the operand registers shift them away.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        aSh_d       = aSh_q;
        bSh_d       = bSh_q;
        dSh_d       = dSh_q;
        br_d        = br_q;
        aMsb_d      = aMsb_q;
        bMsb_d      = bMsb_q;
        diff_d      = diff_q;
        borrowOut_d = borrowOut_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (sub.start) begin
                    aSh_d   = sub.a;
                    bSh_d   = sub.b;
                    br_d    = sub.borrowIn;
                    aMsb_d  = sub.a[WIDTH-1];
                    bMsb_d  = sub.b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                aSh_d = aSh_q >> 1;
                bSh_d = bSh_q >> 1;
                dSh_d = dShifted;
                br_d  = brNext;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    diff_d      = dShifted;
                    borrowOut_d = brNext;
                    zero_d      = (dShifted == '0);
                    negative_d  = dBit;
                    overflow_d  = (aMsb_q != bMsb_q) && (dBit != aMsb_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            aSh_q       <= '0;
            bSh_q       <= '0;
            dSh_q       <= '0;
            br_q        <= 1'b0;
            aMsb_q      <= 1'b0;
            bMsb_q      <= 1'b0;
            diff_q      <= '0;
            borrowOut_q <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            aSh_q       <= aSh_d;
            bSh_q       <= bSh_d;
            dSh_q       <= dSh_d;
            br_q        <= br_d;
            aMsb_q      <= aMsb_d;
            bMsb_q      <= bMsb_d;
            diff_q      <= diff_d;
            borrowOut_q <= borrowOut_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            overflow_q  <= overflow_d;
        end
    end

    assign sub.busy      = (state_q == SHIFT);
    assign sub.done      = (state_q == DONE);
    assign sub.diff      = diff_q;
    assign sub.borrowOut = borrowOut_q;
    assign sub.zero      = zero_q;
    assign sub.negative  = negative_q;
    assign sub.overflow  = overflow_q;
endmodule
